// File: rtl/uart_rot_disp_if.sv
// uart_rot_disp_if: FIFO handshake bundle between the UART core and uart_rot_disp
//   rd_data  : RX FIFO head byte, valid while rx_empty=0
//   rx_empty : RX FIFO empty
//   rd_uart  : RX pop strobe (head consumed on that edge)
//   tx_full  : TX FIFO full
//   wr_uart  : TX push strobe
//   wr_data  : TX byte
// master = FIFO/UART side, slave = uart_rot_disp side.
interface uart_rot_disp_if;
    logic [7:0] rd_data;
    logic       rx_empty;
    logic       rd_uart;
    logic       tx_full;
    logic       wr_uart;
    logic [7:0] wr_data;
    modport master (output rd_data, rx_empty, tx_full, input rd_uart, wr_uart, wr_data);
    modport slave  (input rd_data, rx_empty, tx_full, output rd_uart, wr_uart, wr_data);
endinterface

// File: rtl/uart_rot_disp.sv
// uart_rot_disp: UART-commanded rotating word ring driving a seven-segment word bus
//   clk, reset_n : clock, synchronous active-low reset
//   u            : uart_rot_disp_if.slave (RX pop / TX push handshake)
//   disp_words   : digit k at [(N_DIGITS-k)*W-1 -: W] shows words[k]
//   running/dir  : rotation enable, 0=left 1=right
//   speed        : speed level, period = BASE_PERIOD >> speed
//   load_busy    : high while in LOAD state
// Optional: define ROT_ACK_EN to echo each accepted byte (or '?' for NAK) on TX
// one cycle after the pop; pops then stall while tx_full=1.
module uart_rot_disp #(
    parameter int N_WORDS      = 10,
    parameter int N_DIGITS     = 4,
    parameter int W            = 5,
    parameter int BASE_PERIOD  = 25_000_000,
    parameter int SPEED_LEVELS = 4,
    localparam int SW = SPEED_LEVELS > 1 ? $clog2(SPEED_LEVELS) : 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    uart_rot_disp_if.slave        u,
    output logic [N_DIGITS*W-1:0] disp_words,
    output logic                  running,
    output logic                  dir,
    output logic [SW-1:0]         speed,
    output logic                  load_busy
);
    localparam int CW = $clog2(BASE_PERIOD + 1);
    localparam int AW = $clog2(N_WORDS);
    localparam logic [CW-1:0] BP = CW'(BASE_PERIOD);
    localparam logic [SW-1:0] SMAX = SW'(SPEED_LEVELS - 1);

    typedef enum logic {CMD, LOAD} state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  words_q [N_WORDS];
    logic [W-1:0]  words_d [N_WORDS];
    logic [CW-1:0] cnt_q, cnt_d, lim_m1;
    logic [AW-1:0] wptr_q, wptr_d;
    logic [SW-1:0] speed_q, speed_d;
    logic          running_q, running_d, dir_q, dir_d, load_busy_q, load_busy_d;
    logic          pop, in_cmd, c_pop, l_pop, is_hex, clr, tick, step, rot, go_load, leave;
    logic [7:0]    b;
    logic [3:0]    nib;

    // No pops during reset so queued bytes survive until the block is live.
`ifdef ROT_ACK_EN
    assign pop = reset_n && !u.rx_empty && !u.tx_full;
`else
    assign pop = reset_n && !u.rx_empty;
`endif
    assign u.rd_uart = pop;

    always_comb begin
        b       = u.rd_data;
        in_cmd  = state_q == CMD;
        c_pop   = pop && in_cmd;
        l_pop   = pop && !in_cmd;
        is_hex  = (b >= 8'h30 && b <= 8'h39) || (b >= 8'h41 && b <= 8'h46);
        nib     = b[6] ? b[3:0] + 4'd9 : b[3:0];
        lim_m1  = (BP >> speed_q) - CW'(1);
        tick    = running_q && in_cmd && cnt_q == lim_m1;
        // 'R', '+' and '-' clear the counter and swallow a coincident tick.
        clr     = c_pop && (b == 8'h2B || b == 8'h2D || b == 8'h52);
        step    = c_pop && b == 8'h53 && !running_q;
        rot     = (tick && !clr) || step;
        go_load = c_pop && b == 8'h4C;
        leave   = l_pop && (b == 8'h2E || (is_hex && wptr_q == AW'(N_WORDS - 1)));
        running_d = (c_pop && b == 8'h47) ? 1'b1 : (c_pop && b == 8'h50) ? 1'b0 : running_q;
        dir_d   = dir_q ^ (c_pop && b == 8'h44);
        speed_d = (c_pop && b == 8'h2B && speed_q != SMAX) ? speed_q + 1'b1 :
                  (c_pop && b == 8'h2D && speed_q != '0) ? speed_q - 1'b1 : speed_q;
        cnt_d   = clr ? '0 : (running_q && in_cmd) ? (tick ? '0 : cnt_q + 1'b1) : cnt_q;
        state_d = go_load ? LOAD : leave ? CMD : state_q;
        wptr_d  = go_load ? '0 : (l_pop && is_hex) ? wptr_q + 1'b1 : wptr_q;
        load_busy_d = state_d == LOAD;
        // Rotation uses the pre-command dir, so a 'D' with a tick rotates the old way.
        for (int i = 0; i < N_WORDS; i++) begin
            words_d[i] = !rot ? words_q[i] :
                         dir_q ? words_q[(i + N_WORDS - 1) % N_WORDS] : words_q[(i + 1) % N_WORDS];
            if (c_pop && b == 8'h52) words_d[i] = W'(i);
        end
        if (l_pop && is_hex) words_d[wptr_q] = W'(nib);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= CMD;
            cnt_q       <= '0;
            wptr_q      <= '0;
            speed_q     <= '0;
            running_q   <= 1'b0;
            dir_q       <= 1'b0;
            load_busy_q <= 1'b0;
            for (int i = 0; i < N_WORDS; i++) words_q[i] <= W'(i);
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wptr_q      <= wptr_d;
            speed_q     <= speed_d;
            running_q   <= running_d;
            dir_q       <= dir_d;
            load_busy_q <= load_busy_d;
            words_q     <= words_d;
        end
    end

    for (genvar k = 0; k < N_DIGITS; k++) begin : g_disp
        assign disp_words[(N_DIGITS - k) * W - 1 -: W] = words_q[k];
    end

    assign running   = running_q;
    assign dir       = dir_q;
    assign speed     = speed_q;
    assign load_busy = load_busy_q;

`ifdef ROT_ACK_EN
    logic       wr_uart_q, wr_uart_d, nak;
    logic [7:0] wr_data_q, wr_data_d;

    always_comb begin
        nak = c_pop ? !(b inside {8'h47, 8'h50, 8'h44, 8'h53, 8'h2B, 8'h2D, 8'h52, 8'h4C})
                    : !(is_hex || b == 8'h2E);
        wr_uart_d = pop;
        wr_data_d = !pop ? wr_data_q : nak ? 8'h3F : b;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_uart_q <= 1'b0;
            wr_data_q <= 8'h00;
        end else begin
            wr_uart_q <= wr_uart_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign u.wr_uart = wr_uart_q;
    assign u.wr_data = wr_data_q;
`else
    assign u.wr_uart = 1'b0;
    assign u.wr_data = 8'h00;
`endif
endmodule

// File: tb/tb_uart_rot_disp.sv
// tb_uart_rot_disp: directed self-checking bench for uart_rot_disp
module tb_uart_rot_disp;
    localparam int NW = 10, ND = 4, W = 5, BP = 8, SL = 4;
`ifdef ROT_ACK_EN
    localparam bit ACK = 1'b1;
`else
    localparam bit ACK = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic [ND*W-1:0] disp_words;
    logic            running, dir, load_busy;
    logic [1:0]      speed;
    int              total = 0, bad = 0;
    logic [7:0]      q[$];
    string           s;

    uart_rot_disp_if ifc();

    uart_rot_disp #(.N_WORDS(NW), .N_DIGITS(ND), .W(W), .BASE_PERIOD(BP), .SPEED_LEVELS(SL)) dut (
        .clk(clk), .reset_n(reset_n), .u(ifc), .disp_words(disp_words),
        .running(running), .dir(dir), .speed(speed), .load_busy(load_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (ifc.rd_uart && q.size() > 0) void'(q.pop_front());

    always @(negedge clk) begin
        ifc.rx_empty = q.size() == 0;
        ifc.rd_data  = q.size() > 0 ? q[0] : 8'h00;
    end

    function automatic logic [31:0] d4(input int a, input int b, input int c, input int d);
        return {12'd0, 5'(a), 5'(b), 5'(c), 5'(d)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic [7:0] tx);
        q.push_back(b);
        cyc();
        chk("ack_v", 32'(ifc.wr_uart), 32'(ACK));
        chk("ack_d", 32'(ifc.wr_data), ACK ? 32'(tx) : 32'h0);
    endtask

    initial begin
        ifc.tx_full = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        chk("rst_disp", 32'(disp_words), d4(0, 1, 2, 3));
        chk("rst_run", 32'(running), 0);
        chk("rst_dir", 32'(dir), 0);
        chk("rst_spd", 32'(speed), 0);
        chk("rst_busy", 32'(load_busy), 0);
        chk("rst_wr", 32'(ifc.wr_uart), 0);

        send("G", "G");
        chk("g_run", 32'(running), 1);
        chk("g_disp", 32'(disp_words), d4(0, 1, 2, 3));
        repeat (7) cyc();
        chk("pre_tick", 32'(disp_words), d4(0, 1, 2, 3));
        cyc();
        chk("tick1", 32'(disp_words), d4(1, 2, 3, 4));
        repeat (72) cyc();
        chk("tick10", 32'(disp_words), d4(0, 1, 2, 3));

        send("D", "D");
        chk("d_dir", 32'(dir), 1);
        repeat (6) cyc();
        chk("d_pre", 32'(disp_words), d4(0, 1, 2, 3));
        cyc();
        chk("d_rot", 32'(disp_words), d4(9, 0, 1, 2));
        send("P", "P");
        chk("p_run", 32'(running), 0);
        repeat (20) cyc();
        chk("p_frz", 32'(disp_words), d4(9, 0, 1, 2));

        send("S", "S");
        chk("s1", 32'(disp_words), d4(8, 9, 0, 1));
        send("S", "S");
        chk("s2", 32'(disp_words), d4(7, 8, 9, 0));
        send("S", "S");
        chk("s3", 32'(disp_words), d4(6, 7, 8, 9));

        send("+", "+"); chk("spd1", 32'(speed), 1);
        send("+", "+"); chk("spd2", 32'(speed), 2);
        send("+", "+"); chk("spd3", 32'(speed), 3);
        send("+", "+"); chk("spd3a", 32'(speed), 3);
        send("+", "+"); chk("spd3b", 32'(speed), 3);
        send("-", "-"); chk("spd2b", 32'(speed), 2);

        send("G", "G");
        chk("f0", 32'(disp_words), d4(6, 7, 8, 9));
        cyc(); chk("f1", 32'(disp_words), d4(6, 7, 8, 9));
        cyc(); chk("f2", 32'(disp_words), d4(5, 6, 7, 8));
        cyc(); chk("f3", 32'(disp_words), d4(5, 6, 7, 8));
        cyc(); chk("f4", 32'(disp_words), d4(4, 5, 6, 7));
        send("P", "P");
        repeat (5) cyc();
        chk("f_frz", 32'(disp_words), d4(4, 5, 6, 7));

        send("R", "R");
        chk("r_disp", 32'(disp_words), d4(0, 1, 2, 3));
        chk("r_spd", 32'(speed), 2);
        chk("r_dir", 32'(dir), 1);

        send("L", "L");
        chk("l_busy", 32'(load_busy), 1);
        send("A", "A");
        chk("l_a", 32'(disp_words), d4(10, 1, 2, 3));
        send("5", "5");
        chk("l_5", 32'(disp_words), d4(10, 5, 2, 3));
        send("x", "?");
        chk("l_x", 32'(disp_words), d4(10, 5, 2, 3));
        chk("l_xbusy", 32'(load_busy), 1);
        send(".", ".");
        chk("l_dot", 32'(load_busy), 0);
        chk("l_dotd", 32'(disp_words), d4(10, 5, 2, 3));

        send("L", "L");
        s = "FEDCBA9876";
        for (int i = 0; i < NW; i++) begin
            send(s[i], s[i]);
            if (i == NW - 2) chk("full_busy", 32'(load_busy), 1);
        end
        chk("full_exit", 32'(load_busy), 0);
        chk("full_disp", 32'(disp_words), d4(15, 14, 13, 12));
        send("S", "S");
        chk("full_step", 32'(disp_words), d4(6, 15, 14, 13));

`ifdef ROT_ACK_EN
        ifc.tx_full = 1'b1;
        q.push_back("D"); q.push_back("D"); q.push_back("D");
        cyc();
        chk("stall_rd", 32'(ifc.rd_uart), 0);
        chk("stall_q", 32'(q.size()), 3);
        cyc();
        chk("stall_rd2", 32'(ifc.rd_uart), 0);
        ifc.tx_full = 1'b0;
        #1 chk("rel_rd", 32'(ifc.rd_uart), 1);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("rel_wr", 32'(ifc.wr_uart), 1);
        end
        cyc();
        chk("rel_wr_end", 32'(ifc.wr_uart), 0);
        chk("rel_dir", 32'(dir), 0);
`endif

        send("G", "G");
        send("L", "L");
        send("7", "7");
        chk("ml_busy", 32'(load_busy), 1);
        reset_n = 1'b0;
        cyc();
        reset_n = 1'b1;
        chk("ml_disp", 32'(disp_words), d4(0, 1, 2, 3));
        chk("ml_run", 32'(running), 0);
        chk("ml_busy0", 32'(load_busy), 0);
        chk("ml_spd", 32'(speed), 0);
        chk("ml_dir", 32'(dir), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
